// File: rtl/stepper_seq_if.sv
// Move-command handshake between system controller and stepper sequencer.
// master drives the command fields and valid; slave returns ready.
interface stepper_seq_if #(
    parameter int DIV_W  = 20,
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;
    logic              cmd_half;
    logic [DIV_W-1:0]  step_div;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_half, step_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_half, step_div,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_seq.sv
// Four-coil stepper sequencer: full/half step moves at a programmable rate.
// Ports: CLK_50M, RST_N, cmd (slave), abort, hold_en, coil, busy, done, pos.
module stepper_seq #(
    parameter int DIV_W  = 20,
    parameter int STEP_W = 16,
    parameter int POS_W  = 24
) (
    input  logic             CLK_50M,
    input  logic             RST_N,
    stepper_seq_if.slave     cmd,
    input  logic             abort,
    input  logic             hold_en,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        phase;
    logic [2:0]        phase_nxt;
    logic [2:0]        ph_step;
    logic [2:0]        ph_delta;
    logic [POS_W-1:0]  pos_step;
    logic [POS_W-1:0]  pos_delta;
    logic              dir_q;
    logic              half_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  cnt;
    logic [STEP_W-1:0] remaining;
    logic              accept;
    logic              tick;
    logic              step_en;
    logic              last_step;
    logic              done_nxt;
    logic [3:0]        coil_nxt;

    function automatic logic [3:0] coil_lut(input logic [2:0] p);
        logic [3:0] c;
        c = 4'b0000;
        unique case (p)
            3'd0: c = 4'b0001;
            3'd1: c = 4'b0011;
            3'd2: c = 4'b0010;
            3'd3: c = 4'b0110;
            3'd4: c = 4'b0100;
            3'd5: c = 4'b1100;
            3'd6: c = 4'b1000;
            3'd7: c = 4'b1001;
        endcase
        return c;
    endfunction

    assign accept    = (state == S_IDLE) && cmd.cmd_valid;
    assign tick      = (state == S_RUN) && (cnt == div_q);
    // abort beats a coincident tick
    assign step_en   = tick && !abort;
    assign last_step = step_en && (remaining == STEP_W'(1));

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept && cmd.cmd_steps != '0) state_nxt = S_RUN;
            S_RUN:  if (abort || last_step) state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state == S_IDLE);
        busy          = (state == S_RUN);
    end

    // full step moves two table entries so wave/two-coil parity is kept
    always_comb begin
        ph_step   = half_q ? 3'd1 : 3'd2;
        ph_delta  = dir_q ? ph_step : 3'd0 - ph_step;
        pos_step  = half_q ? POS_W'(1) : POS_W'(2);
        pos_delta = dir_q ? pos_step : '0 - pos_step;
        phase_nxt = step_en ? phase + ph_delta : phase;
        coil_nxt  = 4'b0000;
        if (state_nxt == S_RUN || hold_en) coil_nxt = coil_lut(phase_nxt);
        done_nxt  = (accept && cmd.cmd_steps == '0) ||
                    ((state == S_RUN) && (abort || last_step));
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            phase     <= '0;
            coil      <= '0;
            done      <= 1'b0;
            pos       <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            div_q     <= '0;
            cnt       <= '0;
            remaining <= '0;
        end else begin
            phase <= phase_nxt;
            coil  <= coil_nxt;
            done  <= done_nxt;
            if (step_en) begin
                pos       <= pos + pos_delta;
                remaining <= remaining - STEP_W'(1);
            end
            if (accept) begin
                dir_q     <= cmd.cmd_dir;
                half_q    <= cmd.cmd_half;
                div_q     <= cmd.step_div;
                remaining <= cmd.cmd_steps;
                cnt       <= '0;
            end else if (state == S_RUN) begin
                cnt <= tick ? '0 : cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_stepper_seq.sv
// Randomised and directed bench for stepper_seq against a timeline model.
// A second instance with POS_W=4 shares the stimulus to exercise wrap.
module tb_stepper_seq;
    logic        CLK_50M = 1'b0;
    logic        RST_N   = 1'b0;
    logic        abort   = 1'b0;
    logic        hold_en = 1'b0;
    logic [3:0]  coil, coil4;
    logic        busy, busy4, done, done4;
    logic [23:0] pos;
    logic [3:0]  pos4;

    always #10 CLK_50M = ~CLK_50M;

    stepper_seq_if #(.DIV_W(20), .STEP_W(16)) cif ();
    stepper_seq_if #(.DIV_W(20), .STEP_W(16)) cif4 ();

    assign cif4.cmd_valid = cif.cmd_valid;
    assign cif4.cmd_steps = cif.cmd_steps;
    assign cif4.cmd_dir   = cif.cmd_dir;
    assign cif4.cmd_half  = cif.cmd_half;
    assign cif4.step_div  = cif.step_div;

    stepper_seq #(.DIV_W(20), .STEP_W(16), .POS_W(24)) dut (
        .CLK_50M(CLK_50M), .RST_N(RST_N), .cmd(cif.slave),
        .abort(abort), .hold_en(hold_en), .coil(coil),
        .busy(busy), .done(done), .pos(pos)
    );

    stepper_seq #(.DIV_W(20), .STEP_W(16), .POS_W(4)) dut4 (
        .CLK_50M(CLK_50M), .RST_N(RST_N), .cmd(cif4.slave),
        .abort(abort), .hold_en(hold_en), .coil(coil4),
        .busy(busy4), .done(done4), .pos(pos4)
    );

    int n_total = 0;
    int n_pass  = 0;

    int unsigned tbl [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h4, 4'hC, 4'h8, 4'h9};
    localparam int POS_MOD = 1 << 24;

    int m_busy, m_done, m_phase, m_pos, m_coil;
    int m_left, m_per, m_since, m_dir, m_half;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_phase = 0; m_pos = 0; m_coil = 0;
        m_left = 0; m_per = 1; m_since = 0; m_dir = 0; m_half = 0;
    endtask

    task automatic check_all();
        check_eq("busy",  32'(busy), 32'(m_busy));
        check_eq("ready", 32'(cif.cmd_ready), 32'(m_busy == 0));
        check_eq("done",  32'(done), 32'(m_done));
        check_eq("pos",   32'(pos), 32'(m_pos));
        check_eq("coil",  32'(coil), 32'(m_coil));
        check_eq("pos4",  32'(pos4), 32'(m_pos & 15));
    endtask

    // one clock: predict from inputs sampled before the edge, then compare
    task automatic tick();
        int nb, nd, nph, npos, d;
        nb = m_busy; nd = 0; nph = m_phase; npos = m_pos;
        if (m_busy == 0) begin
            if (cif.cmd_valid) begin
                if (cif.cmd_steps == 0) nd = 1;
                else begin
                    nb = 1;
                    m_left  = int'(cif.cmd_steps);
                    m_per   = int'(cif.step_div) + 1;
                    m_since = 0;
                    m_dir   = int'(cif.cmd_dir);
                    m_half  = int'(cif.cmd_half);
                end
            end
        end else begin
            m_since++;
            if (abort) begin
                nb = 0; nd = 1;
            end else if (m_since % m_per == 0) begin
                d = m_half ? 1 : 2;
                if (!m_dir) d = -d;
                nph  = (m_phase + d + 8) % 8;
                npos = (m_pos + d + POS_MOD) % POS_MOD;
                m_left--;
                if (m_left == 0) begin nb = 0; nd = 1; end
            end
        end
        m_coil = (nb != 0 || hold_en) ? int'(tbl[nph]) : 0;
        @(posedge CLK_50M);
        #1;
        m_busy = nb; m_done = nd; m_phase = nph; m_pos = npos;
        check_all();
    endtask

    task automatic issue(input int steps, input bit dir, input bit half,
                         input int div);
        cif.cmd_valid = 1'b1;
        cif.cmd_steps = 16'(steps);
        cif.cmd_dir   = dir;
        cif.cmd_half  = half;
        cif.step_div  = 20'(div);
        tick();
        cif.cmd_valid = 1'b0;
        cif.cmd_steps = 16'($urandom);
        cif.cmd_dir   = 1'($urandom);
        cif.cmd_half  = 1'($urandom);
        cif.step_div  = 20'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", 32'(busy), 32'(0));
    endtask

    int p0;

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_steps = '0;
        cif.cmd_dir   = 1'b0;
        cif.cmd_half  = 1'b0;
        cif.step_div  = '0;
        model_reset();
        repeat (2) @(posedge CLK_50M);
        #1;
        check_all();
        RST_N = 1'b1;
        tick();

        // half-step forward, div=2
        hold_en = 1'b0;
        issue(4, 1'b1, 1'b1, 2);
        check_eq("t1_coil_accept", 32'(coil), 32'h1);
        wait_idle(40);
        check_eq("t1_pos", 32'(pos), 32'd4);
        tick();

        // full-step reverse from phase 4, div=0, coil held at end
        hold_en = 1'b1;
        tick();
        issue(3, 1'b0, 1'b0, 0);
        wait_idle(10);
        check_eq("t2_coil_end", 32'(coil), 32'h8);
        check_eq("t2_pos", 32'(pos), 32'(POS_MOD - 2));
        tick();

        // abort on the 5th tick of a long move
        hold_en = 1'b0;
        p0 = m_pos;
        issue(100, 1'b1, 1'b1, 9);
        repeat (49) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t3_pos", 32'(pos), 32'((p0 + 4) % POS_MOD));
        tick();

        // zero-step command with hold torque
        hold_en = 1'b1;
        tick();
        issue(0, 1'b1, 1'b0, 3);
        check_eq("t4_busy", 32'(busy), 32'(0));
        repeat (2) tick();
        hold_en = 1'b0;

        // reset in mid-move
        issue(20, 1'b1, 1'b1, 1);
        repeat (7) tick();
        #3 RST_N = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge CLK_50M);
        @(posedge CLK_50M);
        #1 RST_N = 1'b1;
        tick();

        // wrap on the 4-bit instance
        issue(3, 1'b0, 1'b1, 0);
        wait_idle(10);
        check_eq("wrap_dn", 32'(pos4), 32'd13);
        tick();
        issue(5, 1'b1, 1'b1, 1);
        wait_idle(20);
        check_eq("wrap_up", 32'(pos4), 32'd2);
        tick();

        // random commands, aborts, hold changes and bus noise
        for (int i = 0; i < 80; i++) begin
            hold_en = 1'($urandom_range(0, 1));
            abort   = ($urandom_range(0, 7) == 0);
            issue(int'($urandom_range(0, 12)), 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 4)));
            for (int n = 0; n < 200 && busy; n++) begin
                abort         = ($urandom_range(0, 39) == 0);
                cif.cmd_valid = 1'($urandom);
                if ($urandom_range(0, 15) == 0) hold_en = ~hold_en;
                tick();
            end
            abort         = 1'b0;
            cif.cmd_valid = 1'b0;
            check_eq("rnd_idle", 32'(busy), 32'(0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/stepper_seq.md
# stepper_seq

Parametrised four-coil stepper motor sequencer. It accepts a move command over a valid/ready handshake: step count, direction, and full- or half-step mode. It generates the coil phase pattern at a programmable step rate and tracks absolute position. Abort and idle hold-torque are supported. It sits between the system controller and the motor driver pins, replacing fixed free-running step generation.

## Interface
Parameters:
- DIV_W, 20, width of step-period divider and `step_div` input
- STEP_W, 16, width of `cmd_steps`
- POS_W, 24, width of position counter, two's complement, counts half-steps

Ports:
- CLK_50M  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  move command present
- cmd_ready  out  1  block can accept a command; equals idle
- cmd_steps  in  STEP_W  number of steps to move; sampled on accept
- cmd_dir  in  1  1 = forward (phase increments), 0 = reverse; sampled on accept
- cmd_half  in  1  1 = half-step, 0 = full-step; sampled on accept
- step_div  in  DIV_W  step period minus one, in clocks; sampled on accept
- abort  in  1  terminate current move
- hold_en  in  1  keep coils energised while idle
- coil  out  4  coil drive {D,C,B,A}
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at end of every accepted command
- pos  out  POS_W  absolute position in half-steps

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1, `busy`=0.
  - RUN: `cmd_ready`=0, `busy`=1.
- IDLE→RUN: on `cmd_valid & cmd_ready` with `cmd_steps`≠0. The edge latches `dir`, `half`, `div`, `remaining`=`cmd_steps`, and clears the divider counter.
- IDLE with `cmd_valid` and `cmd_steps`=0: the command is accepted, no state change, and `done` pulses on the next cycle. There is no coil or `pos` change.
- In RUN, the divider counts 0..`div`, and a step tick fires when the count equals `div`, then the count returns to 0.
- Each tick performs the following:
  - Phase update. Half mode: phase ±1 mod 8. Full mode: phase ±2 mod 8, so parity is preserved (even phase gives wave drive, odd phase gives two-coil drive).
  - Position update. `pos` ±1 in half mode, ±2 in full mode, wrapping mod 2^POS_W.
  - Count update. `remaining` −1.
- RUN→IDLE: on the tick where `remaining` becomes 0. `done` is high for the following cycle.
- `abort` in RUN: the FSM goes to IDLE on that edge, `remaining` is discarded, phase and `pos` are kept, and `done` pulses next cycle.
- `abort` coincident with a tick: abort wins and no step is taken.
- `abort` in IDLE is ignored, including when it coincides with a command accept.
- Phase table, index → {D,C,B,A}:
  - 0=0001, 1=0011, 2=0010, 3=0110
  - 4=0100, 5=1100, 6=1000, 7=1001
- `coil` register:
  - Loads `table[phase]` when the next state is RUN or `hold_en`=1.
  - Loads 0000 otherwise.
- Phase persists across commands. It is never reset except by `RST_N`.
- Reset values:
  - State IDLE, phase 0, `coil`=0000, `pos`=0, `busy`=0, `done`=0, `cmd_ready`=1.
  - Divider and `remaining` are 0.
- Reset mid-move: all of the above apply immediately (asynchronously), and no `done` pulse is generated.

## Timing
- Accept at edge k:
  - `busy` rises after edge k.
  - `coil` shows the current phase pattern after edge k (energise without step).
  - The first step edge is k+`div`+1, and subsequent steps follow every `div`+1 cycles.
- With `div`=0, the block steps every clock.
- The last step (N) lands at edge k+N·(`div`+1).
  - After that edge: `busy`=0 and `done`=1.
  - After the next edge: `done`=0.
  - The earliest next accept is the cycle after the last step, since `cmd_ready` is high then.
- `phase`, `coil` and `pos` change on the same edge as the tick.
- A `hold_en` change is reflected on `coil` one cycle later while idle.
- `cmd_*` and `step_div` changes while busy have no effect.

## Test plan
- Reset, `hold_en`=0, accept steps=4, dir=1, half=1, div=2:
  - `coil` 0001 from accept, then 0011, 0010, 0110, 0100 at 3-cycle spacing.
  - `pos`=4, then `done` pulses for one cycle and `coil`=0000.
- From phase 4, accept steps=3, dir=0, half=0, div=0:
  - phase 4→2→0→6 on consecutive cycles, `coil` ending at 1000.
  - `pos` decreases by 6.
  - `busy` high for exactly 3 cycles.
- Accept steps=100, div=9, assert `abort` on the cycle of the 5th tick:
  - `pos` changes by exactly 4, then IDLE.
  - `done` pulses once and `cmd_ready`=1 the next cycle.
- Accept steps=0 → one `done` pulse. `busy` stays 0 and `pos`/`coil` are unchanged. With `hold_en`=1, `coil`=`table[phase]` throughout.
- Position wrap, POS_W=4:
  - `pos`=0, dir=0, half=1, 3 steps → `pos`=13.
  - Then dir=1, 5 steps → `pos`=2.
- Assert `RST_N` low mid-move: outputs go to reset values immediately, with no `done` pulse. After release, a new command is accepted normally.
